button_counter_4b: RTL and testbench
====================================

Name: button_counter_4b

Overview:
Upstream feeder for the 4-bit binary display decoder in lab 2 problem 1. It takes raw active-low push-buttons and slide switches, then synchronizes and debounces the buttons. It keeps a 4-bit up/down/loadable counter whose value drives the decoder's 4-bit input `a`. A one-cycle wrap flag is also provided for LEDs or later stages.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button change (10 ms at 50 MHz); must be >= 2; the bench uses 4.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
key_up_n  input  1  raw button, active-low (0 = pressed), asynchronous to clk
key_down_n  input  1  raw button, active-low, asynchronous
key_load_n  input  1  raw button, active-low, asynchronous
sw  input  4  load value from slide switches, sampled through 2-flop sync
count  output  4  current counter value, to the decoder input `a`
wrap  output  1  one-cycle pulse when count wraps (15->0 up or 0->15 down)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - count=0, wrap=0.
  - Sync flops = 1 (released).
  - Debounced states = released.
  - Debounce counters = 0.
  - sw sync flops = 0.
  - Reset overrides everything, including a debounce in progress.
- Synchronizer:
  - Each key and each sw bit passes through 2 flops before use.
  - No logic reads the first flop.
- Debounce, per key, independent:
  - `stable` holds the accepted pressed state (1 = pressed).
  - The debounce counter increments on each cycle where the synced pressed value != `stable`.
  - The counter clears to 0 on any cycle where they are equal.
  - When the counter = DEBOUNCE_CYCLES-1 and the values still differ, `stable` toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change `stable`.
- Edge detect:
  - Register `stable_d`.
  - Press event = stable & ~stable_d, high exactly 1 cycle per accepted press.
  - Release generates no event.
- Counter update, at the edge where events are high, with this priority:
  - load event: count <= synced sw, wrap=0.
  - up and down events in the same cycle: no change, wrap=0.
  - up: count <= count+1 mod 16; wrap=1 iff old count=15.
  - down: count <= count-1 mod 16; wrap=1 iff old count=0.
  - otherwise: hold, wrap=0.
- wrap is registered and high for exactly the one cycle following the wrapping edge.
- Latency: a raw key falling edge held steady shows up in count exactly DEBOUNCE_CYCLES+3 rising edges later. That is 2 sync edges, DEBOUNCE_CYCLES debounce edges, and 1 count edge.
- Holding a key produces exactly one event; there is no auto-repeat.
- Keys released across reset:
  - A key held through reset deassertion is seen as a new press.
  - It is debounced and counted once.
- count is always a valid 0..15 value; it has no X after reset.

Test Plan:
- Reset, then hold key_up_n=0 for 20 cycles (DEBOUNCE_CYCLES=4) -> count goes 0->1 exactly 7 edges after the press; no further change while held; wrap stays 0.
- Bounce key_up_n low for 3 cycles, high for 1, repeated 5 times, then release -> count unchanged at 0.
- Press up 16 times from 0 -> count reaches 15, then 0 on the 16th; wrap=1 only in the cycle after the 15->0 update.
- From count=0, press down -> count=15 and wrap pulses once. Then set sw=4'b1010 and press load -> count=10, wrap=0.
- Press up and down so their accepted events coincide in the same cycle -> count holds. Press load together with up -> count = sw.
- Hold key_up_n=0, pulse rst_n=0 for 2 cycles mid-debounce, keep key held -> count=0 at reset, then becomes 1 exactly 7 edges after rst_n returns high.

Source files
------------

// File: rtl/button_counter_4b.sv
// Synchronise, debounce and edge-detect three active-low keys feeding a 4-bit up/down/load counter.
// Raw key edge to count change is DEBOUNCE_CYCLES+3 clocks; no backpressure, one event per accepted press.
module button_counter_4b #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_load_n,
  input  logic [3:0] sw,
  output logic [3:0] count,
  output logic       wrap
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int K_UP   = 0;
  localparam int K_DOWN = 1;
  localparam int K_LOAD = 2;

  logic [2:0]    key_s1;
  logic [2:0]    key_s2;
  logic [3:0]    sw_s1;
  logic [3:0]    sw_s2;
  logic [2:0]    pressed;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    press_ev;
  logic [CW-1:0] deb_cnt [3];
  logic [3:0]    count_nxt;
  logic          wrap_nxt;

  // Keys idle high, so the synchroniser resets to "released".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= {key_load_n, key_down_n, key_up_n};
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  assign pressed = ~key_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable   <= '0;
      stable_d <= '0;
      for (int k = 0; k < 3; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int k = 0; k < 3; k++) begin
        if (pressed[k] == stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DB_LAST) begin
          stable[k]  <= ~stable[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + CW'(1);
        end
      end
    end
  end

  // Only the released->pressed transition of the accepted state is an event.
  assign press_ev = stable & ~stable_d;

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (press_ev[K_LOAD]) begin
      count_nxt = sw_s2;
    end else if (press_ev[K_UP] && press_ev[K_DOWN]) begin
      count_nxt = count;
    end else if (press_ev[K_UP]) begin
      count_nxt = count + 4'd1;
      wrap_nxt  = (count == 4'd15);
    end else if (press_ev[K_DOWN]) begin
      count_nxt = count - 4'd1;
      wrap_nxt  = (count == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_button_counter_4b.sv
// Bench for button_counter_4b: vector table, hand sequences and a cycle-level reference model.
module tb_button_counter_4b;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_down_n = 1'b1;
  logic       key_load_n = 1'b1;
  logic [3:0] sw = 4'd0;
  logic [3:0] count;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  button_counter_4b #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .key_load_n (key_load_n),
    .sw         (sw),
    .count      (count),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keys reach the debouncer two clocks late, a key is accepted
  // once it has disagreed with the accepted state for N consecutive clocks, and
  // the counter reacts one clock after acceptance.
  logic [2:0] key_q [$];
  logic [3:0] sw_q [$];
  bit   [2:0] m_stable;
  bit   [2:0] m_pend;
  int         diff_since [3];
  int         cyc = 0;
  int         m_count = 0;
  bit         m_wrap = 1'b0;
  bit         m_valid = 1'b0;

  initial begin : model
    logic [2:0] kv;
    logic [3:0] sv;
    logic [2:0] ev;
    bit         p;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        key_q = '{3'b111, 3'b111};
        sw_q  = '{4'd0, 4'd0};
        m_stable = '0;
        m_pend   = '0;
        m_count  = 0;
        m_wrap   = 1'b0;
        m_valid  = 1'b1;
        for (int k = 0; k < 3; k++) diff_since[k] = -1;
      end else if (m_valid) begin
        kv = key_q.pop_front();
        key_q.push_back({key_load_n, key_down_n, key_up_n});
        sv = sw_q.pop_front();
        sw_q.push_back(sw);
        ev = m_pend;
        m_pend = '0;
        for (int k = 0; k < 3; k++) begin
          p = ~kv[k];
          if (p != m_stable[k]) begin
            if (diff_since[k] < 0) diff_since[k] = cyc;
            if (cyc - diff_since[k] + 1 >= N) begin
              m_stable[k]   = p;
              m_pend[k]     = p;
              diff_since[k] = -1;
            end
          end else begin
            diff_since[k] = -1;
          end
        end
        m_wrap = 1'b0;
        if (ev[2]) begin
          m_count = int'(sv);
        end else if (ev[0] && ev[1]) begin
          m_count = m_count;
        end else if (ev[0]) begin
          m_wrap  = (m_count == 15);
          m_count = (m_count + 1) % 16;
        end else if (ev[1]) begin
          m_wrap  = (m_count == 0);
          m_count = (m_count + 15) % 16;
        end
      end
      cyc++;
    end
  end

  initial begin : model_checker
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("model_count", int'(count), m_count);
        check("model_wrap", int'(wrap), int'(m_wrap));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_count", int'(count), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
  endtask

  // pr bits: [0]=up [1]=down [2]=load; press for hold clocks, then release for hold clocks.
  task automatic pulse_keys(input logic [2:0] pr, input int hold, output int wraps);
    wraps = 0;
    @(negedge clk);
    {key_load_n, key_down_n, key_up_n} = ~pr;
    repeat (hold) begin
      @(negedge clk);
      wraps += int'(wrap);
    end
    {key_load_n, key_down_n, key_up_n} = 3'b111;
    repeat (hold) begin
      @(negedge clk);
      wraps += int'(wrap);
    end
  endtask

  typedef struct {
    logic [2:0] keys;
    logic [3:0] swv;
    int         exp_count;
    int         exp_wraps;
  } vec_t;

  vec_t tbl [13];

  initial begin : stimulus
    int wraps;
    int wsum;

    tbl[0]  = '{3'b001, 4'd0,  1,  0};
    tbl[1]  = '{3'b010, 4'd0,  0,  0};
    tbl[2]  = '{3'b010, 4'd0,  15, 1};
    tbl[3]  = '{3'b001, 4'd0,  0,  1};
    tbl[4]  = '{3'b100, 4'hA,  10, 0};
    tbl[5]  = '{3'b001, 4'hA,  11, 0};
    tbl[6]  = '{3'b100, 4'hF,  15, 0};
    tbl[7]  = '{3'b001, 4'hF,  0,  1};
    tbl[8]  = '{3'b100, 4'h3,  3,  0};
    tbl[9]  = '{3'b011, 4'h3,  3,  0};
    tbl[10] = '{3'b101, 4'h6,  6,  0};
    tbl[11] = '{3'b010, 4'h6,  5,  0};
    tbl[12] = '{3'b110, 4'h9,  9,  0};

    // Held key: exactly one increment, N+3 clocks after the press.
    do_reset();
    wsum = 0;
    @(negedge clk);
    key_up_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      wsum += int'(wrap);
      if (i == N + 2) check("latency_before", int'(count), 0);
      if (i == N + 3) check("latency_at", int'(count), 1);
    end
    check("held_count", int'(count), 1);
    check("held_wrap", wsum, 0);
    key_up_n = 1'b1;
    repeat (10) @(negedge clk);

    // Bounces of N-1 low clocks never get accepted.
    do_reset();
    repeat (5) begin
      key_up_n = 1'b0;
      repeat (N - 1) @(negedge clk);
      key_up_n = 1'b1;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_count", int'(count), 0);

    // Sixteen ups from zero, wrapping on the last.
    for (int i = 0; i < 16; i++) begin
      pulse_keys(3'b001, 10, wraps);
      check($sformatf("up%0d_count", i), int'(count), (i + 1) % 16);
      check($sformatf("up%0d_wrap", i), wraps, (i == 15) ? 1 : 0);
    end

    for (int i = 0; i < 13; i++) begin
      sw = tbl[i].swv;
      pulse_keys(tbl[i].keys, 10, wraps);
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
      check($sformatf("tbl%0d_wrap", i), wraps, tbl[i].exp_wraps);
    end

    // Coincident up/down holds; load beats up.
    pulse_keys(3'b011, 10, wraps);
    check("updown_count", int'(count), 9);
    check("updown_wrap", wraps, 0);
    sw = 4'b0110;
    pulse_keys(3'b101, 10, wraps);
    check("loadup_count", int'(count), 6);

    // Reset mid-debounce with the key still held.
    @(negedge clk);
    key_up_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_count", int'(count), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == N + 2) check("midrst_before", int'(count), 0);
      if (i == N + 3) check("midrst_at", int'(count), 1);
    end
    check("midrst_held", int'(count), 1);
    key_up_n = 1'b1;
    repeat (10) @(negedge clk);

    // Random key activity, switches and occasional resets against the model.
    repeat (600) begin
      @(negedge clk);
      key_up_n   = ($urandom_range(0, 2) != 0);
      key_down_n = ($urandom_range(0, 2) != 0);
      key_load_n = ($urandom_range(0, 3) != 0);
      sw         = 4'($urandom_range(0, 15));
      rst_n      = ($urandom_range(0, 39) != 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    rst_n = 1'b1;
    {key_load_n, key_down_n, key_up_n} = 3'b111;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
